// File: rtl/systolic_tile_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_tile_ctrl
//  Description : Job controller for a systolic PE array. Accepts a job
//                (START rising edge + M/K/N sizes), walks every output tile
//                in tm-major order and sequences operand-SRAM reads, PE
//                accumulator clears and output-SRAM row writes per tile.
//                Reports completion with a one-cycle pulse and a job cycle
//                count.
//  Ports       : CLK, RST (async, active-high)
//                START, STALL, M_SIZE_in, K_SIZE_in, N_SIZE_in   - job port
//                OPND1_RD_EN_out / OPND1_ADDR_out                - A SRAM
//                OPND2_RD_EN_out / OPND2_ADDR_out                - B SRAM
//                PE_CLEAR_out                                    - PE array
//                OUT_WR_EN_out / OUT_ROW_SEL_out / OUT_ADDR_out  - C SRAM
//                BUSY_out, IS_FINISHED_out, CYCLE_COUNT_out      - status
//  Revision    : 1.0 - initial release
// ============================================================================
module systolic_tile_ctrl #(
    parameter int PE_ARRAY_NUM_ROWS      = 4,
    parameter int PE_ARRAY_NUM_ROWS_LOG2 = 2,
    parameter int PE_ARRAY_NUM_COLS      = 4,
    parameter int PE_ARRAY_NUM_COLS_LOG2 = 2,
    parameter int MAX_M_SIZE_LOG2        = 9,
    parameter int MAX_K_SIZE_LOG2        = 9,
    parameter int MAX_N_SIZE_LOG2        = 9,
    parameter int OPND1_SRAM_AWIDTH      = 10,
    parameter int OPND2_SRAM_AWIDTH      = 10,
    parameter int OUT_SRAM_AWIDTH        = 10
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              START,
    input  logic                              STALL,
    input  logic [MAX_M_SIZE_LOG2-1:0]        M_SIZE_in,
    input  logic [MAX_K_SIZE_LOG2-1:0]        K_SIZE_in,
    input  logic [MAX_N_SIZE_LOG2-1:0]        N_SIZE_in,
    output logic                              OPND1_RD_EN_out,
    output logic [OPND1_SRAM_AWIDTH-1:0]      OPND1_ADDR_out,
    output logic                              OPND2_RD_EN_out,
    output logic [OPND2_SRAM_AWIDTH-1:0]      OPND2_ADDR_out,
    output logic                              PE_CLEAR_out,
    output logic                              OUT_WR_EN_out,
    output logic [PE_ARRAY_NUM_ROWS_LOG2-1:0] OUT_ROW_SEL_out,
    output logic [OUT_SRAM_AWIDTH-1:0]        OUT_ADDR_out,
    output logic                              BUSY_out,
    output logic                              IS_FINISHED_out,
    output logic [31:0]                       CYCLE_COUNT_out
);

    // The step counter indexes k in FEED, the drain cycle in DRAIN and the
    // row in WRITE, so it is sized by the reduction depth.
    localparam int c_SW = MAX_K_SIZE_LOG2;
    localparam logic [c_SW-1:0] c_DRAIN_LAST = c_SW'(PE_ARRAY_NUM_ROWS + PE_ARRAY_NUM_COLS - 2);
    localparam logic [c_SW-1:0] c_WRITE_LAST = c_SW'(PE_ARRAY_NUM_ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CLEAR = 3'd2,
        S_FEED  = 3'd3,
        S_DRAIN = 3'd4,
        S_WRITE = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;

    // Set when START was low on the previous cycle; cleared by reset so a
    // START held high across reset release is not taken as a new request.
    logic                       r_start_low;
    logic                       w_accept;

    logic [MAX_M_SIZE_LOG2-1:0] r_m;
    logic [MAX_K_SIZE_LOG2-1:0] r_k;
    logic [MAX_N_SIZE_LOG2-1:0] r_n;
    logic [MAX_M_SIZE_LOG2-1:0] r_mt;
    logic [MAX_N_SIZE_LOG2-1:0] r_nt;
    logic [MAX_M_SIZE_LOG2-1:0] r_tm;
    logic [MAX_N_SIZE_LOG2-1:0] r_tn;
    logic [c_SW-1:0]            r_step;
    logic [31:0]                r_cycle_count;

    logic [MAX_M_SIZE_LOG2:0]   w_m_round;
    logic [MAX_N_SIZE_LOG2:0]   w_n_round;
    logic [MAX_M_SIZE_LOG2-1:0] w_mt;
    logic [MAX_N_SIZE_LOG2-1:0] w_nt;
    logic                       w_zero_size;
    logic                       w_feed_last;
    logic                       w_drain_last;
    logic                       w_write_last;
    logic                       w_tn_last;
    logic                       w_tm_last;
    logic                       w_row_valid;
    logic [OPND1_SRAM_AWIDTH-1:0] w_opnd1_addr;
    logic [OPND2_SRAM_AWIDTH-1:0] w_opnd2_addr;
    logic [OUT_SRAM_AWIDTH-1:0]   w_out_addr;

    assign w_accept = (r_state == S_IDLE) && START && r_start_low;

    // Tile counts: ceil(size / array dimension)
    assign w_m_round = {1'b0, r_m} + (MAX_M_SIZE_LOG2+1)'(PE_ARRAY_NUM_ROWS - 1);
    assign w_n_round = {1'b0, r_n} + (MAX_N_SIZE_LOG2+1)'(PE_ARRAY_NUM_COLS - 1);
    assign w_mt      = MAX_M_SIZE_LOG2'(w_m_round >> PE_ARRAY_NUM_ROWS_LOG2);
    assign w_nt      = MAX_N_SIZE_LOG2'(w_n_round >> PE_ARRAY_NUM_COLS_LOG2);

    assign w_zero_size  = (r_m == '0) || (r_k == '0) || (r_n == '0);
    assign w_feed_last  = (r_step == c_SW'(r_k - MAX_K_SIZE_LOG2'(1)));
    assign w_drain_last = (r_step == c_DRAIN_LAST);
    assign w_write_last = (r_step == c_WRITE_LAST);
    assign w_tn_last    = (r_tn == (r_nt - MAX_N_SIZE_LOG2'(1)));
    assign w_tm_last    = (r_tm == (r_mt - MAX_M_SIZE_LOG2'(1)));

    // Rows past M in the bottom tile are padding and must not be written.
    assign w_row_valid = ((32'(r_tm) * 32'(PE_ARRAY_NUM_ROWS)) + 32'(r_step)) < 32'(r_m);

    // Addresses wrap modulo 2^AWIDTH; the low bits of a product only depend
    // on the low bits of its operands, so computing at AWIDTH is exact.
    assign w_opnd1_addr = OPND1_SRAM_AWIDTH'(r_tm) * OPND1_SRAM_AWIDTH'(r_k)
                        + OPND1_SRAM_AWIDTH'(r_step);
    assign w_opnd2_addr = OPND2_SRAM_AWIDTH'(r_tn) * OPND2_SRAM_AWIDTH'(r_k)
                        + OPND2_SRAM_AWIDTH'(r_step);
    assign w_out_addr   = (OUT_SRAM_AWIDTH'(r_tm) * OUT_SRAM_AWIDTH'(r_nt)
                        + OUT_SRAM_AWIDTH'(r_tn)) * OUT_SRAM_AWIDTH'(PE_ARRAY_NUM_ROWS)
                        + OUT_SRAM_AWIDTH'(r_step);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs. Strobes are qualified with !STALL so a frozen
    // step is issued exactly once, on the first unstalled cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        OPND1_RD_EN_out = 1'b0;
        OPND1_ADDR_out  = '0;
        OPND2_RD_EN_out = 1'b0;
        OPND2_ADDR_out  = '0;
        PE_CLEAR_out    = 1'b0;
        OUT_WR_EN_out   = 1'b0;
        OUT_ROW_SEL_out = '0;
        OUT_ADDR_out    = '0;
        IS_FINISHED_out = 1'b0;
        BUSY_out        = (r_state != S_IDLE);

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_state_nxt = w_zero_size ? S_DONE : S_CLEAR;
            end
            S_CLEAR: begin
                PE_CLEAR_out = !STALL;
                w_state_nxt  = S_FEED;
            end
            S_FEED: begin
                OPND1_RD_EN_out = !STALL;
                OPND2_RD_EN_out = !STALL;
                OPND1_ADDR_out  = w_opnd1_addr;
                OPND2_ADDR_out  = w_opnd2_addr;
                if (w_feed_last) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_drain_last) begin
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                OUT_WR_EN_out   = !STALL && w_row_valid;
                OUT_ROW_SEL_out = r_step[PE_ARRAY_NUM_ROWS_LOG2-1:0];
                OUT_ADDR_out    = w_out_addr;
                if (w_write_last) begin
                    w_state_nxt = (w_tm_last && w_tn_last) ? S_DONE : S_CLEAR;
                end
            end
            S_DONE: begin
                IS_FINISHED_out = !STALL;
                w_state_nxt     = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (STALL && (r_state != S_IDLE)) begin
            w_state_nxt = r_state;
        end
    end

    // ------------------------------------------------------------------
    // Job registers, tile/step counters and the cycle counter
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_start_low   <= 1'b0;
            r_m           <= '0;
            r_k           <= '0;
            r_n           <= '0;
            r_mt          <= '0;
            r_nt          <= '0;
            r_tm          <= '0;
            r_tn          <= '0;
            r_step        <= '0;
            r_cycle_count <= '0;
        end else begin
            r_start_low <= !START;
            if (w_accept) begin
                r_m           <= M_SIZE_in;
                r_k           <= K_SIZE_in;
                r_n           <= N_SIZE_in;
                r_cycle_count <= '0;
            end else if (!STALL) begin
                case (r_state)
                    S_LOAD: begin
                        r_mt          <= w_mt;
                        r_nt          <= w_nt;
                        r_tm          <= '0;
                        r_tn          <= '0;
                        r_step        <= '0;
                        r_cycle_count <= r_cycle_count + 32'd1;
                    end
                    S_CLEAR: begin
                        r_step        <= '0;
                        r_cycle_count <= r_cycle_count + 32'd1;
                    end
                    S_FEED: begin
                        r_step        <= w_feed_last ? '0 : r_step + c_SW'(1);
                        r_cycle_count <= r_cycle_count + 32'd1;
                    end
                    S_DRAIN: begin
                        r_step        <= w_drain_last ? '0 : r_step + c_SW'(1);
                        r_cycle_count <= r_cycle_count + 32'd1;
                    end
                    S_WRITE: begin
                        r_cycle_count <= r_cycle_count + 32'd1;
                        if (w_write_last) begin
                            r_step <= '0;
                            if (w_tn_last) begin
                                r_tn <= '0;
                                r_tm <= r_tm + MAX_M_SIZE_LOG2'(1);
                            end else begin
                                r_tn <= r_tn + MAX_N_SIZE_LOG2'(1);
                            end
                        end else begin
                            r_step <= r_step + c_SW'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign CYCLE_COUNT_out = r_cycle_count;

endmodule
`default_nettype wire

// File: tb/tb_systolic_tile_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_systolic_tile_ctrl
//  Description : Self-checking bench for systolic_tile_ctrl. Directed jobs
//                push their expected output-SRAM writes and completion
//                cycle counts into queues; a monitor pops and compares them
//                whenever the DUT writes or finishes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_tile_ctrl;

    logic       CLK;
    logic       RST;
    logic       START;
    logic       STALL;
    logic [8:0] M_SIZE_in;
    logic [8:0] K_SIZE_in;
    logic [8:0] N_SIZE_in;
    logic       OPND1_RD_EN_out;
    logic [9:0] OPND1_ADDR_out;
    logic       OPND2_RD_EN_out;
    logic [9:0] OPND2_ADDR_out;
    logic       PE_CLEAR_out;
    logic       OUT_WR_EN_out;
    logic [1:0] OUT_ROW_SEL_out;
    logic [9:0] OUT_ADDR_out;
    logic       BUSY_out;
    logic       IS_FINISHED_out;
    logic [31:0] CYCLE_COUNT_out;

    systolic_tile_ctrl dut (
        .CLK             (CLK),
        .RST             (RST),
        .START           (START),
        .STALL           (STALL),
        .M_SIZE_in       (M_SIZE_in),
        .K_SIZE_in       (K_SIZE_in),
        .N_SIZE_in       (N_SIZE_in),
        .OPND1_RD_EN_out (OPND1_RD_EN_out),
        .OPND1_ADDR_out  (OPND1_ADDR_out),
        .OPND2_RD_EN_out (OPND2_RD_EN_out),
        .OPND2_ADDR_out  (OPND2_ADDR_out),
        .PE_CLEAR_out    (PE_CLEAR_out),
        .OUT_WR_EN_out   (OUT_WR_EN_out),
        .OUT_ROW_SEL_out (OUT_ROW_SEL_out),
        .OUT_ADDR_out    (OUT_ADDR_out),
        .BUSY_out        (BUSY_out),
        .IS_FINISHED_out (IS_FINISHED_out),
        .CYCLE_COUNT_out (CYCLE_COUNT_out)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int addr;
        int row;
    } wr_t;

    wr_t wr_q[$];
    int  fin_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_wr     = 0;
    int n_rd     = 0;
    int n_clr    = 0;
    int n_fin    = 0;
    int t_busy   = 0;
    int t_fin    = 0;
    logic prev_busy = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // Monitor / scoreboard
    always @(negedge CLK) begin
        if (BUSY_out && !prev_busy) t_busy = cyc;
        prev_busy = BUSY_out;
        if (OPND1_RD_EN_out) n_rd++;
        if (PE_CLEAR_out)    n_clr++;
        if (OUT_WR_EN_out) begin
            n_wr++;
            if (wr_q.size() == 0) begin
                check("unexpected_write", OUT_ADDR_out, -1);
            end else begin
                wr_t e;
                e = wr_q.pop_front();
                check("wr_addr", OUT_ADDR_out, e.addr);
                check("wr_row", OUT_ROW_SEL_out, e.row);
            end
        end
        if (IS_FINISHED_out) begin
            n_fin++;
            t_fin = cyc;
            if (fin_q.size() == 0) begin
                check("unexpected_finish", CYCLE_COUNT_out, -1);
            end else begin
                check("cycle_count", CYCLE_COUNT_out, fin_q.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #2;
        end
    endtask

    task automatic clear_counts();
        n_wr = 0; n_rd = 0; n_clr = 0; n_fin = 0;
    endtask

    task automatic push_writes(input int first, input int last);
        for (int a = first; a <= last; a++) begin
            wr_t e;
            e.addr = a;
            e.row  = a % 4;
            wr_q.push_back(e);
        end
    endtask

    // Drive sizes, START low for one cycle, then high; accepted next edge.
    task automatic start_job(input int m, input int k, input int n);
        M_SIZE_in = 9'(m);
        K_SIZE_in = 9'(k);
        N_SIZE_in = 9'(n);
        START = 1'b0;
        tick(1);
        START = 1'b1;
    endtask

    task automatic wait_fin(input int target, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            #1;
            if (n_fin >= target) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("finish_timeout", n_fin, target);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; START = 1'b0; STALL = 1'b0;
        M_SIZE_in = '0; K_SIZE_in = '0; N_SIZE_in = '0;
        tick(3);
        check("rst_busy", BUSY_out, 0);
        check("rst_rd_en", OPND1_RD_EN_out, 0);
        check("rst_wr_en", OUT_WR_EN_out, 0);
        check("rst_cycle_count", CYCLE_COUNT_out, 0);
        RST = 1'b0;
        tick(2);
        check("idle_busy", BUSY_out, 0);
        check("idle_finished", IS_FINISHED_out, 0);

        // Job 1: 16x16x16, START held high afterwards
        clear_counts();
        push_writes(0, 63);
        fin_q.push_back(449);
        start_job(16, 16, 16);
        wait_fin(1, 1000);
        check("j1_latency", t_fin - t_busy, 449);
        tick(60);
        check("j1_no_restart_busy", BUSY_out, 0);
        check("j1_fin_once", n_fin, 1);
        check("j1_writes", n_wr, 64);
        check("j1_reads", n_rd, 256);
        check("j1_clears", n_clr, 16);

        // Job 2: M=5 K=3 N=2, padded rows suppressed
        clear_counts();
        for (int a = 0; a < 5; a++) begin
            wr_t e;
            e.addr = a;
            e.row  = a % 4;
            wr_q.push_back(e);
        end
        fin_q.push_back(31);
        start_job(5, 3, 2);
        wait_fin(1, 200);
        check("j2_latency", t_fin - t_busy, 31);
        tick(3);
        check("j2_writes", n_wr, 5);
        check("j2_reads", n_rd, 6);

        // Job 3: K=0 -> LOAD then DONE
        clear_counts();
        fin_q.push_back(1);
        start_job(4, 0, 4);
        wait_fin(1, 50);
        check("j3_latency", t_fin - t_busy, 1);
        tick(3);
        check("j3_reads", n_rd, 0);
        check("j3_clears", n_clr, 0);
        check("j3_writes", n_wr, 0);
        check("j3_count_hold", CYCLE_COUNT_out, 1);

        // Job 4: STALL for 5 cycles at FEED k=7 of tile 0
        clear_counts();
        push_writes(0, 63);
        fin_q.push_back(449);
        start_job(16, 16, 16);
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            #1;
            if (BUSY_out) break;
        end
        check("j4_load_seen", BUSY_out, 1);
        tick(1);            // CLEAR
        tick(8);            // FEED k=7
        STALL = 1'b1;
        @(negedge CLK); #1;
        check("j4_stall_rd_en", OPND1_RD_EN_out, 0);
        check("j4_stall_rd2_en", OPND2_RD_EN_out, 0);
        check("j4_stall_addr1", OPND1_ADDR_out, 7);
        check("j4_stall_addr2", OPND2_ADDR_out, 7);
        tick(4);
        @(negedge CLK); #1;
        check("j4_stall_hold_addr", OPND1_ADDR_out, 7);
        check("j4_stall_hold_busy", BUSY_out, 1);
        tick(1);
        STALL = 1'b0;
        @(negedge CLK); #1;
        check("j4_resume_rd_en", OPND1_RD_EN_out, 1);
        check("j4_resume_addr", OPND1_ADDR_out, 7);
        @(negedge CLK); #1;
        check("j4_next_addr", OPND1_ADDR_out, 8);
        wait_fin(1, 1000);
        check("j4_latency", t_fin - t_busy, 454);
        tick(3);
        check("j4_reads", n_rd, 256);

        // Job 5: reset during WRITE, then restart
        clear_counts();
        push_writes(0, 0);
        start_job(16, 16, 16);
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            #1;
            if (n_wr >= 1) break;
        end
        check("j5_first_write", n_wr, 1);
        tick(1);
        RST = 1'b1;
        #1;
        check("j5_rst_busy", BUSY_out, 0);
        check("j5_rst_wr_en", OUT_WR_EN_out, 0);
        check("j5_rst_addr", OUT_ADDR_out, 0);
        check("j5_rst_row", OUT_ROW_SEL_out, 0);
        check("j5_rst_count", CYCLE_COUNT_out, 0);
        tick(2);
        RST = 1'b0;
        tick(4);
        check("j5_held_start_ignored", BUSY_out, 0);
        check("j5_queue_drained", wr_q.size(), 0);
        clear_counts();
        push_writes(0, 63);
        fin_q.push_back(449);
        start_job(16, 16, 16);
        wait_fin(1, 1000);
        check("j5_latency", t_fin - t_busy, 449);
        check("j5_writes", n_wr, 64);

        // Job 6: START edge while busy is ignored
        clear_counts();
        push_writes(0, 3);
        fin_q.push_back(15);
        start_job(4, 2, 4);
        tick(3);
        START = 1'b0;
        tick(1);
        START = 1'b1;
        wait_fin(1, 100);
        check("j6_latency", t_fin - t_busy, 15);
        tick(20);
        check("j6_idle_after_done", BUSY_out, 0);
        check("j6_fin_once", n_fin, 1);
        push_writes(0, 3);
        fin_q.push_back(15);
        start_job(4, 2, 4);
        wait_fin(2, 100);
        tick(3);
        check("j6_second_job", n_fin, 2);
        check("j6_writes", n_wr, 8);

        check("final_wr_q_empty", wr_q.size(), 0);
        check("final_fin_q_empty", fin_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/systolic_tile_ctrl.md
Name: systolic_tile_ctrl

Overview:
- Control responder for the systolic-array job interface. It accepts a job (START plus M/K/N sizes), walks every output tile of the PE array, and drives operand-SRAM reads, PE accumulator clears and output-SRAM writes for each tile.
- It signals job completion with a one-cycle IS_FINISHED_out pulse and reports the cycle count for the job.
- It sits between the host/testbench job port and the PE array plus its three SRAMs.

Parameters:
- PE_ARRAY_NUM_ROWS, 4, PE rows; each opnd1 word holds one operand per row.
- PE_ARRAY_NUM_ROWS_LOG2, 2, log2 of the rows value.
- PE_ARRAY_NUM_COLS, 4, PE columns; each opnd2 word holds one operand per column.
- PE_ARRAY_NUM_COLS_LOG2, 2, log2 of the columns value.
- MAX_M_SIZE_LOG2 / MAX_K_SIZE_LOG2 / MAX_N_SIZE_LOG2, 9 each, widths of the size inputs.
- OPND1_SRAM_AWIDTH, OPND2_SRAM_AWIDTH, OUT_SRAM_AWIDTH, 10 each, address widths.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset; asynchronous, active-high.
- START  in  1  job request; level input, rising edge accepted (may be held high).
- STALL  in  1  global freeze.
- M_SIZE_in  in  MAX_M_SIZE_LOG2  rows of A/C.
- K_SIZE_in  in  MAX_K_SIZE_LOG2  reduction depth.
- N_SIZE_in  in  MAX_N_SIZE_LOG2  columns of B/C.
- OPND1_RD_EN_out  out  1  A read strobe.
- OPND1_ADDR_out  out  OPND1_SRAM_AWIDTH  A word address.
- OPND2_RD_EN_out  out  1  B read strobe.
- OPND2_ADDR_out  out  OPND2_SRAM_AWIDTH  B word address.
- PE_CLEAR_out  out  1  zero all PE accumulators.
- OUT_WR_EN_out  out  1  C write strobe.
- OUT_ROW_SEL_out  out  PE_ARRAY_NUM_ROWS_LOG2  PE row being written.
- OUT_ADDR_out  out  OUT_SRAM_AWIDTH  C word address.
- BUSY_out  out  1  high in any state except IDLE.
- IS_FINISHED_out  out  1  one-cycle done pulse.
- CYCLE_COUNT_out  out  32  cycles used by the last or current job.

Behaviour:
- Reset (asynchronous, any time including mid-job):
  - FSM goes to IDLE; all outputs are 0; CYCLE_COUNT_out is 0; the START edge register is cleared.
  - START held high through reset release is not a new job until START goes low and high again.
- START handling:
  - START is registered; a job is accepted only in IDLE, on a 0-to-1 transition of START.
  - Sizes are sampled on acceptance; size changes afterwards are ignored.
  - START edges while BUSY are ignored and not queued.
- Tile counts: MT = ceil(M/ROWS), NT = ceil(N/COLS). Tiles run in tm-major order (tm outer, tn inner).
- States and transitions:
  - IDLE: waits for an accepted START.
  - LOAD: 1 cycle; latches sizes and computes MT/NT. If M, K or N is 0, next state is DONE; otherwise CLEAR.
  - CLEAR: 1 cycle; PE_CLEAR_out=1.
  - FEED: K cycles, k=0..K-1. Both RD_EN are 1; OPND1_ADDR = tm*K+k; OPND2_ADDR = tn*K+k.
  - DRAIN: ROWS+COLS-1 cycles; all strobes 0 (skew flush plus 1-cycle SRAM latency absorbed).
  - WRITE: ROWS cycles, r=0..ROWS-1.
    - OUT_ROW_SEL_out = r; OUT_ADDR = (tm*NT+tn)*ROWS + r.
    - OUT_WR_EN_out = 1 only when tm*ROWS+r < M; padded rows consume the cycle with WR_EN=0.
    - After r=ROWS-1: go to CLEAR for the next tile, or DONE after the last tile.
  - DONE: 1 cycle; IS_FINISHED_out=1, BUSY_out=1; next state IDLE.
- Addresses are computed at full precision and truncated modulo 2^AWIDTH (wrap, no error).
- STALL=1, in any non-IDLE state:
  - State and counters freeze; all strobes (RD_EN, WR_EN, PE_CLEAR, IS_FINISHED) are forced 0; addresses hold.
  - The frozen step is re-issued on the first cycle with STALL=0.
  - STALL in IDLE does not block START acceptance; the job then freezes in LOAD.
- CYCLE_COUNT_out:
  - Cleared on START acceptance.
  - Increments on every non-stalled cycle in LOAD through WRITE; does not increment in DONE.
  - Holds its value in IDLE until the next accepted START.
- Per-tile cost: 1 + K + (ROWS+COLS-1) + ROWS cycles.

Test Plan:
- Default parameters, M=K=N=16, START rising and held high: 16 tiles × 28 cycles.
  - IS_FINISHED_out pulses exactly once, 449 cycles after LOAD; CYCLE_COUNT_out=449.
  - 64 writes occur, to OUT_ADDR 0..63 in order; no restart while START stays high.
- M=5, K=3, N=2: MT=2, NT=1, 2 tiles × 15 cycles.
  - Writes occur only at addresses 0,1,2,3,4; the tile-1 write cycles for r=1..3 have WR_EN=0.
  - CYCLE_COUNT_out=31.
- K=0: LOAD then DONE; IS_FINISHED_out pulses in the 2nd cycle after acceptance.
  - No RD_EN, WR_EN or CLEAR strobe ever asserts; CYCLE_COUNT_out=1.
- STALL held high for 5 cycles when FEED is at k=7 of tile 0 (M=K=N=16):
  - Strobes are 0 and addresses hold at 7 during the stall; k=7 is issued after release.
  - Finish is delayed by exactly 5 cycles; CYCLE_COUNT_out is still 449.
- RST pulsed mid-WRITE, then START toggled 0→1:
  - All outputs read 0 immediately on reset; the new job restarts from tile 0 with OUT_ADDR 0.
- Second START edge while BUSY: ignored.
  - After DONE, the FSM stays in IDLE until START goes low and then high again.
